// File: rtl/param_data_mem.sv
// Word-addressable data memory with configurable latency and a busy_wait handshake.
// Optional access counters (rd_count/wr_count) are built when DM_ACCESS_STATS_EN is defined.
module param_data_mem #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              busy_wait,
    output logic              err
`ifdef DM_ACCESS_STATS_EN
   ,output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    localparam int         DEPTH    = 2**ADDR_W;
    localparam logic [9:0] CNT_LOAD = 10'(LATENCY - 1);

    state_t              state_q, state_d;
    logic                opWrite_q, opWrite_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   readData_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                validReq, holdMatch, evalIdle, accept, errSet;
    logic                doAccess, accWrite;
    logic [ADDR_W-1:0]   accAddr;
    logic [DATA_W-1:0]   accData;

    // A HOLD whose request no longer matches behaves exactly like IDLE in the same cycle.
    always_comb begin
        validReq  = read ^ write;
        holdMatch = validReq && (write == opWrite_q) &&
                    (address == addr_q) && (write_data == data_q);
        evalIdle  = (state_q == IDLE) || ((state_q == HOLD) && !holdMatch);
        accept    = evalIdle && validReq;
        errSet    = evalIdle && read && write;

        state_d   = state_q;
        opWrite_d = opWrite_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        doAccess  = 1'b0;
        accWrite  = opWrite_q;
        accAddr   = addr_q;
        accData   = data_q;

        if (accept) begin
            opWrite_d = write;
            addr_d    = address;
            data_d    = write_data;
            cnt_d     = CNT_LOAD;
            if (LATENCY == 1) begin
                doAccess = 1'b1;
                accWrite = write;
                accAddr  = address;
                accData  = write_data;
                state_d  = HOLD;
            end else begin
                state_d  = BUSY;
            end
        end else if (state_q == BUSY) begin
            // The access completes on the edge that brings cnt down to zero.
            cnt_d = (cnt_q == 10'd0) ? 10'd0 : cnt_q - 10'd1;
            if (cnt_q <= 10'd1) begin
                doAccess = 1'b1;
                state_d  = HOLD;
            end
        end else if (evalIdle) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opWrite_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            readData_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            opWrite_q <= opWrite_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_q     <= errSet;
            if (doAccess) begin
                if (accWrite) begin
                    mem[accAddr] <= accData;
                end else begin
                    readData_q <= mem[accAddr];
                end
            end
        end
    end

    assign busy_wait = (accept && !rst) || (state_q == BUSY);
    assign read_data = readData_q;
    assign err       = err_q;

`ifdef DM_ACCESS_STATS_EN
    logic [15:0] rdCount_q, wrCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else if (doAccess) begin
            if (accWrite && (wrCount_q != 16'hFFFF)) begin
                wrCount_q <= wrCount_q + 16'd1;
            end
            if (!accWrite && (rdCount_q != 16'hFFFF)) begin
                rdCount_q <= rdCount_q + 16'd1;
            end
        end
    end

    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;
`endif

endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench for param_data_mem: instances with LATENCY 100, 4 and 1.
// Stats counters are checked only when DM_ACCESS_STATS_EN is defined.
module tb_param_data_mem;
    logic       clk;
    logic       rst  [3];
    logic       rd   [3];
    logic       wr   [3];
    logic [7:0] addr [3];
    logic [7:0] wd   [3];
    logic [7:0] rdd  [3];
    logic       bw   [3];
    logic       er   [3];
`ifdef DM_ACCESS_STATS_EN
    logic [15:0] rc [3];
    logic [15:0] wc [3];
`endif

    int total = 0;
    int bad   = 0;
    int edges;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    param_data_mem #(.DATA_W(8), .ADDR_W(8), .LATENCY(100)) dut0 (
        .clk(clk), .rst(rst[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
        .write_data(wd[0]), .read_data(rdd[0]), .busy_wait(bw[0]), .err(er[0])
`ifdef DM_ACCESS_STATS_EN
       ,.rd_count(rc[0]), .wr_count(wc[0])
`endif
    );

    param_data_mem #(.DATA_W(8), .ADDR_W(8), .LATENCY(4)) dut1 (
        .clk(clk), .rst(rst[1]), .read(rd[1]), .write(wr[1]), .address(addr[1]),
        .write_data(wd[1]), .read_data(rdd[1]), .busy_wait(bw[1]), .err(er[1])
`ifdef DM_ACCESS_STATS_EN
       ,.rd_count(rc[1]), .wr_count(wc[1])
`endif
    );

    param_data_mem #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) dut2 (
        .clk(clk), .rst(rst[2]), .read(rd[2]), .write(wr[2]), .address(addr[2]),
        .write_data(wd[2]), .read_data(rdd[2]), .busy_wait(bw[2]), .err(er[2])
`ifdef DM_ACCESS_STATS_EN
       ,.rd_count(rc[2]), .wr_count(wc[2])
`endif
    );

    task automatic applyStimulus(input int u, input logic r, input logic w,
                                 input logic [7:0] a, input logic [7:0] d);
        rd[u]   = r;
        wr[u]   = w;
        addr[u] = a;
        wd[u]   = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until busy_wait drops, sampled on the falling edge.
    task automatic measureBusy(input int u, input int maxEdges, output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!bw[u] || n >= maxEdges) break;
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1;
            applyStimulus(u, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        #1;
        checkOutput("reset_busy", 32'(bw[0]), 32'd0);
        checkOutput("reset_rdata", 32'(rdd[0]), 32'h00);
        checkOutput("reset_err", 32'(er[0]), 32'd0);

        // Read of an untouched word
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 8'h19, 8'h00);
        #1;
        checkOutput("rd0_busy_rise", 32'(bw[0]), 32'd1);
        measureBusy(0, 200, edges);
        checkOutput("rd0_busy_edges", 32'(edges), 32'd100);
        checkOutput("rd0_rdata", 32'(rdd[0]), 32'h00);
        checkOutput("rd0_err", 32'(er[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);

        // Write held well past completion
        applyStimulus(0, 1'b0, 1'b1, 8'h19, 8'd45);
        #1;
        checkOutput("wr_busy_rise", 32'(bw[0]), 32'd1);
        measureBusy(0, 200, edges);
        checkOutput("wr_busy_edges", 32'(edges), 32'd100);
        begin
            int highCycles = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bw[0]) highCycles++;
            end
            checkOutput("wr_hold_busy", 32'(highCycles), 32'd0);
        end
`ifdef DM_ACCESS_STATS_EN
        checkOutput("wr_hold_count", 32'(wc[0]), 32'd1);
`endif

        // Switch straight from held write to a read of the same address
        applyStimulus(0, 1'b1, 1'b0, 8'h19, 8'd45);
        #1;
        checkOutput("rd1_busy_rise", 32'(bw[0]), 32'd1);
        repeat (99) @(posedge clk);
        @(negedge clk);
        checkOutput("rd1_busy_edge99", 32'(bw[0]), 32'd1);
        checkOutput("rd1_rdata_edge99", 32'(rdd[0]), 32'h00);
        @(negedge clk);
        checkOutput("rd1_busy_edge100", 32'(bw[0]), 32'd0);
        checkOutput("rd1_rdata_edge100", 32'(rdd[0]), 32'd45);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);

        // Illegal read+write in IDLE
        applyStimulus(0, 1'b1, 1'b1, 8'h19, 8'h99);
        #1;
        checkOutput("err_busy", 32'(bw[0]), 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("err_pulse", 32'(er[0]), 32'd1);
        @(negedge clk);
        checkOutput("err_clear", 32'(er[0]), 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 8'h19, 8'h00);
        measureBusy(0, 200, edges);
        checkOutput("err_rd_edges", 32'(edges), 32'd100);
        checkOutput("err_mem_intact", 32'(rdd[0]), 32'd45);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);

        // Reset in the middle of a write
        applyStimulus(0, 1'b0, 1'b1, 8'h40, 8'hAA);
        repeat (49) @(negedge clk);
        rst[0] = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bw[0]), 32'd0);
        checkOutput("abort_rdata", 32'(rdd[0]), 32'h00);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
        measureBusy(0, 200, edges);
        checkOutput("abort_rd_edges", 32'(edges), 32'd100);
        checkOutput("abort_rd_data", 32'(rdd[0]), 32'h00);
`ifdef DM_ACCESS_STATS_EN
        checkOutput("abort_wr_count", 32'(wc[0]), 32'd0);
        checkOutput("abort_rd_count", 32'(rc[0]), 32'd1);
`endif
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);

        // LATENCY=4: back-to-back writes then reads
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'h10, 8'd65);
        #1;
        checkOutput("l4_wr1_rise", 32'(bw[1]), 32'd1);
        measureBusy(1, 20, edges);
        checkOutput("l4_wr1_edges", 32'(edges), 32'd4);
        applyStimulus(1, 1'b0, 1'b1, 8'h19, 8'd45);
        #1;
        checkOutput("l4_wr2_rise", 32'(bw[1]), 32'd1);
        measureBusy(1, 20, edges);
        checkOutput("l4_wr2_edges", 32'(edges), 32'd4);
        applyStimulus(1, 1'b1, 1'b0, 8'h10, 8'h00);
        measureBusy(1, 20, edges);
        checkOutput("l4_rd1_edges", 32'(edges), 32'd4);
        checkOutput("l4_rd1_data", 32'(rdd[1]), 32'd65);
        applyStimulus(1, 1'b1, 1'b0, 8'h19, 8'h00);
        measureBusy(1, 20, edges);
        checkOutput("l4_rd2_edges", 32'(edges), 32'd4);
        checkOutput("l4_rd2_data", 32'(rdd[1]), 32'd45);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);

        // LATENCY=1: single-cycle accesses
        @(negedge clk);
        applyStimulus(2, 1'b0, 1'b1, 8'h05, 8'h77);
        #1;
        checkOutput("l1_wr_rise", 32'(bw[2]), 32'd1);
        measureBusy(2, 20, edges);
        checkOutput("l1_wr_edges", 32'(edges), 32'd1);
        applyStimulus(2, 1'b1, 1'b0, 8'h05, 8'h00);
        #1;
        checkOutput("l1_rd_rise", 32'(bw[2]), 32'd1);
        measureBusy(2, 20, edges);
        checkOutput("l1_rd_edges", 32'(edges), 32'd1);
        checkOutput("l1_rd_data", 32'(rdd[2]), 32'h77);
        applyStimulus(2, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_data_mem.md
Name: param_data_mem

Overview:
Parametrised successor of the processor's data memory. It provides a word-addressable synchronous memory with configurable data width, address width and access latency, and uses a cycle-exact FSM-driven busy_wait handshake. It sits beside the control unit and register file. busy_wait stalls the PC and register-file writeback while an access is in flight. Illegal simultaneous read and write requests are flagged, and a held request is never re-executed.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words
LATENCY, 100, clock edges from request acceptance to access completion; legal range 1..1023

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
read  input  1  read request level
write  input  1  write request level
address  input  ADDR_W  word address
write_data  input  DATA_W  store data
read_data  output  DATA_W  load data, registered
busy_wait  output  1  stall to the processor
err  output  1  one-cycle pulse when read and write are both high in IDLE
rd_count  output  16  completed reads; present only with DM_ACCESS_STATS_EN
wr_count  output  16  completed writes; present only with DM_ACCESS_STATS_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy_wait=0, read_data=0, err=0, cnt=0, every memory word = 0 (cleared at the reset edge). Reset mid-access aborts it: no memory write, read_data=0.
- FSM states:
  - IDLE: no access pending.
  - BUSY: access in flight.
  - HOLD: access done, the same request is still asserted.
- Valid request: exactly one of read/write is high.
- IDLE with a valid request at a posedge:
  - latch op, address and write_data;
  - load cnt=LATENCY-1;
  - go to BUSY.
- IDLE with read=write=1:
  - err=1 for the next cycle only;
  - no access, stay in IDLE;
  - busy_wait stays 0.
- BUSY:
  - cnt decrements each posedge while cnt!=0.
  - At the posedge where cnt==0, perform the access using the latched values: write → mem[addr]<=data; read → read_data<=mem[addr].
  - Then go to HOLD.
  - Request inputs changing during BUSY are ignored.
- busy_wait (combinational): 1 when (IDLE and valid request and !rst) or state==BUSY; otherwise 0.
  - It rises in the same cycle the request appears.
  - It is high for exactly LATENCY rising edges, counting the accepting edge as edge 1 and completing on edge LATENCY.
  - It falls right after the completing edge.
- HOLD:
  - busy_wait=0.
  - Stay in HOLD while op, address and write_data all equal the latched values.
  - If any of them differs, or read=write=0, return to IDLE in the same cycle. The new request is then evaluated as in IDLE, so busy_wait rises combinationally and acceptance happens on the next edge.
  - This prevents re-execution of an instruction held across cycles.
- LATENCY=1: the access completes on the accepting edge, and busy_wait is high for one cycle.
- Address wraps naturally within ADDR_W; there is no out-of-range case.
- read_data holds its last value until the next completed read or reset.

Optional Feature:
Macro DM_ACCESS_STATS_EN.
- Defined: rd_count and wr_count ports exist. Each increments by 1 on every completed read or write respectively, and saturates at 16'hFFFF. Both reset to 0. Aborted or err requests do not count.
- Undefined: the ports and the counters are absent, with no other behavioural change.

Test Plan:
- rst high 1 cycle, then read addr 0x19 → busy_wait high 100 edges; read_data=0x00; err=0.
- write addr 0x19 data 45 (LATENCY=100), held → busy_wait high exactly 100 cycles then 0. Memory is not rewritten while held in HOLD: with DM_ACCESS_STATS_EN, wr_count=1 after 300 held cycles.
- After the write, change to read addr 0x19 → busy_wait rises the same cycle; read_data=45 after edge 100, unchanged before.
- Back-to-back writes 0x10←65 and 0x19←45, then reads of both, using an instance with LATENCY=4 → busy_wait pulses of 4 cycles each; reads return 65 and 45.
- read=write=1 in IDLE → err pulse 1 cycle, busy_wait=0, memory unchanged.
- rst asserted at cycle 50 of a write of 0xAA → busy_wait=0 next cycle; a subsequent read of that address returns 0x00. An instance with LATENCY=1 → busy_wait high 1 cycle per access.
